// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // E-stage operand mux select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Memory-wait FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } hz_state_t;

    // x0 is hard-wired to zero and is never a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// Latency: n/a (wiring only).
// Backpressure: stall/flush outputs are the backpressure into the pipeline.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [4:0] Rs1D, Rs2D;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic [4:0] RdM, RdW;
    logic       LoadE, PCSrcE;
    logic       RegWriteM, RegWriteW;
    logic       MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    fwd_sel_t   ForwardAE, ForwardBE;
    logic       MemErr;

    // pipeline side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output LoadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemErr
    );

    // hazard controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  LoadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemErr
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding comparator for one E-stage source operand (M beats W).
// Latency: combinational.
// Backpressure: none.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic       reg_write_m,
    input  logic [4:0] rd_m,
    input  logic       reg_write_w,
    input  logic [4:0] rd_w,
    input  logic [4:0] rs,
    output fwd_sel_t   sel
);

    // youngest producer (M) has priority over W; x0 never forwards
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && rd_m != REG_ZERO && rd_m == rs)
            sel = FWD_MEM;
        else if (reg_write_w && rd_w != REG_ZERO && rd_w == rs)
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use stall, branch flush, memory-wait freeze with timeout trap; optional perf counters (HAZARD_PERF_EN).
// Latency: controls are combinational on inputs and the registered wait FSM state.
// Backpressure: a pending data-memory access freezes every pipeline register and bubbles W.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic           clk,
    input  logic           reset_n,
    hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    hz_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mem_stall;
    logic          lw_stall;

    fwd_sel u_fwd_a (
        .reg_write_m (hz.RegWriteM),
        .rd_m        (hz.RdM),
        .reg_write_w (hz.RegWriteW),
        .rd_w        (hz.RdW),
        .rs          (hz.Rs1E),
        .sel         (hz.ForwardAE)
    );

    fwd_sel u_fwd_b (
        .reg_write_m (hz.RegWriteM),
        .rd_m        (hz.RdM),
        .reg_write_w (hz.RegWriteW),
        .rd_w        (hz.RdW),
        .rs          (hz.Rs2E),
        .sel         (hz.ForwardBE)
    );

    // wait FSM state and consecutive-wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next state; memStall is Mealy in RUN so the first wait cycle already freezes
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_stall = 1'b0;
        case (state)
            RUN: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    mem_stall = 1'b1;
                    state_nxt = MEM_WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.MemReadyM) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (cnt == CNT_LAST)
                        state_nxt = TRAP;
                    else
                        cnt_nxt = cnt + CW'(1);
                end
            end
            TRAP: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign lw_stall  = hz.LoadE && hz.RdE != REG_ZERO &&
                       (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    assign hz.MemErr = (state == TRAP);

    // stall/flush priority: memory freeze > taken branch > load-use
    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (mem_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else if (lw_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // saturating stall/flush event counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.StallF && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if ((hz.FlushD || hz.FlushE) && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model expectations, monitor compares each cycle.
// Latency: expectations are for the same cycle's combinational outputs.
// Backpressure: n/a.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int T = 4;

    typedef struct packed {
        logic [11:0] ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hz       (hif),
        .StallCnt (stall_cnt_o),
        .FlushCnt (flush_cnt_o)
    );
`else
    hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hif)
    );
`endif

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // reference state: consecutive stalled memory cycles and trap flag
    int          m_wait = 0;
    bit          m_trap = 1'b0;
    logic [31:0] m_sc = '0;
    logic [31:0] m_fc = '0;

    function automatic logic [1:0] fwd_m(input logic rwm, input logic [4:0] rdm,
                                         input logic rww, input logic [4:0] rdw,
                                         input logic [4:0] rs);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    // one clock of stimulus; expected outputs for this cycle go to the scoreboard
    task automatic cycle(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                         input logic loade, pc, rwm, rww, req, rdy, rst_n,
                         input bit preload);
        logic ms, lw, sf, fd, fe;
        logic [1:0] fa, fb;
        exp_t e;
        @(posedge clk);
        #1;
        hif.Rs1D = rs1d; hif.Rs2D = rs2d; hif.Rs1E = rs1e; hif.Rs2E = rs2e;
        hif.RdE = rde; hif.RdM = rdm; hif.RdW = rdw;
        hif.LoadE = loade; hif.PCSrcE = pc; hif.RegWriteM = rwm; hif.RegWriteW = rww;
        hif.MemReqM = req; hif.MemReadyM = rdy;
        reset_n = rst_n;
        if (!rst_n) begin
            m_wait = 0; m_trap = 1'b0; m_sc = '0; m_fc = '0;
        end
`ifdef HAZARD_PERF_EN
        if (preload) begin
            force dut.stall_cnt = 32'hFFFF_FFFE;
            #0 release dut.stall_cnt;
            m_sc = 32'hFFFF_FFFE;
        end
`endif
        if (m_trap)          ms = 1'b1;
        else if (m_wait > 0) ms = !rdy;
        else                 ms = req && !rdy;
        lw = loade && rde != 0 && (rde == rs1d || rde == rs2d);
        fa = fwd_m(rwm, rdm, rww, rdw, rs1e);
        fb = fwd_m(rwm, rdm, rww, rdw, rs2e);
        sf = ms || (!pc && lw);
        fd = !ms && pc;
        fe = !ms && (pc || lw);
        e.ctl = {sf, sf, ms, ms, fd, fe, ms, fa, fb, m_trap};
        e.sc  = m_sc;
        e.fc  = m_fc;
        sb.push_back(e);
        if (rst_n) begin
            if (!m_trap) begin
                if (ms) begin
                    m_wait++;
                    if (m_wait == T) m_trap = 1'b1;
                end else begin
                    m_wait = 0;
                end
            end
            if (sf && m_sc != 32'hFFFF_FFFF) m_sc++;
            if ((fd || fe) && m_fc != 32'hFFFF_FFFF) m_fc++;
        end
    endtask

    task automatic quiet(input logic rst_n);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rst_n, 1'b0);
    endtask

    task automatic mem(input logic req, input logic rdy);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, req, rdy, 1'b1, 1'b0);
    endtask

    // monitor: compare outputs against the oldest expectation every cycle
    always @(negedge clk) begin
        exp_t e;
        logic [11:0] act;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD,
                   hif.FlushE, hif.FlushW, hif.ForwardAE, hif.ForwardBE, hif.MemErr};
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL ctl t=%0t got %b want %b (SF SD SE SM FD FE FW FA FB ME)",
                         $time, act, e.ctl);
            end
`ifdef HAZARD_PERF_EN
            tests++;
            if (stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
                fails++;
                $display("FAIL perf t=%0t got stall=%h flush=%h want stall=%h flush=%h",
                         $time, stall_cnt_o, flush_cnt_o, e.sc, e.fc);
            end
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
        hif.RdM = 0; hif.RdW = 0; hif.LoadE = 0; hif.PCSrcE = 0;
        hif.RegWriteM = 0; hif.RegWriteW = 0; hif.MemReqM = 0; hif.MemReadyM = 0;

        quiet(1'b0); quiet(1'b0); quiet(1'b1);

        // forwarding: M beats W, then W alone
        cycle(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 1, 0, 0, 1'b1, 1'b0);
        cycle(0, 0, 5, 0, 0, 5, 5, 0, 0, 0, 1, 0, 0, 1'b1, 1'b0);
        // load-use on Rs2D, then released; RdE=x0 never stalls
        cycle(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        quiet(1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        // branch wins over an illegal concurrent load-use
        cycle(3, 0, 0, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 1'b1, 1'b0);
        quiet(1'b1);
        // memory wait of 3 cycles then ready; same-cycle completion never stalls
        mem(1, 0); mem(1, 0); mem(1, 0); mem(1, 1); mem(1, 1); quiet(1'b1);
        // load-use masked by memory freeze
        cycle(7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 1, 0, 1'b1, 1'b0);
        mem(0, 1); quiet(1'b1);
        // timeout trap, sticky despite ready, cleared by reset
        repeat (6) mem(1, 0);
        mem(1, 1); mem(0, 1);
        quiet(1'b0); quiet(1'b1); quiet(1'b1);
        // reset in the middle of a wait
        mem(1, 0); mem(0, 0); quiet(1'b0); quiet(1'b1);

`ifdef HAZARD_PERF_EN
        // saturation: preload near all-ones, then keep stalling
        cycle(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        cycle(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        cycle(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        quiet(1'b1);
        quiet(1'b0); quiet(1'b1);
`endif

        // randomized traffic with small register indices for frequent matches
        for (int i = 0; i < 600; i++) begin
            if (m_trap && $urandom_range(0, 3) == 0) begin
                quiet(1'b0);
            end else begin
                cycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      1'b1, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Generates the stall, flush (clear) and forwarding-select controls consumed by the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand muxes.
- Adds a registered memory-wait FSM that freezes the pipeline while data memory is not ready, with timeout trap detection.

Parameters:
- MEM_TIMEOUT, 64, max consecutive wait cycles before the trap; legal range 2..65535.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers in D
- Rs1E, Rs2E, RdE  in  5  source/destination registers in E
- RdM, RdW  in  5  destination registers in M and W
- LoadE  in  1  instruction in E is a load (ResultSrcE == 2'b01)
- PCSrcE  in  1  taken branch/jump resolved in E
- RegWriteM, RegWriteW  in  1  register writeback enables in M and W
- MemReqM  in  1  load/store active in M
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  synchronous clear into D, E and W
- ForwardAE, ForwardBE  out  2  E-operand select: 00 register file, 01 W result, 10 M ALU result
- MemErr  out  1  sticky memory-timeout trap flag

Behaviour:
- Reset (reset_n=0, async): FSM=RUN, wait counter=0, MemErr=0. All outputs are combinational on this state and the inputs, so with quiet inputs every output reads 0.
- Forwarding (combinational, per operand; A shown):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W.
  - ForwardBE uses Rs2E under the same rules.
- lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall is asserted in these cases:
  - in RUN when MemReqM && !MemReadyM (Mealy, same cycle);
  - in MEM_WAIT when !MemReadyM;
  - always in TRAP.
- FSM states:
  - RUN: on MemReqM && !MemReadyM, next=MEM_WAIT and cnt<=1.
  - MEM_WAIT: if MemReadyM, next=RUN and cnt<=0; the stall is released in the same cycle. Else if cnt==MEM_TIMEOUT-1, next=TRAP. Else cnt<=cnt+1.
  - TRAP: MemErr=1. Pipeline stays frozen until reset_n; MemReadyM is ignored.
- Output priority:
  - memStall: StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD=FlushE=0, so state is held and not cleared, and lwStall/PCSrcE are masked.
  - else PCSrcE: FlushD=1, FlushE=1, no stalls.
  - else lwStall: StallF=1, StallD=1, FlushE=1.
  - else all 0.
- Simultaneous lwStall and PCSrcE cannot occur legally (single instruction in E). If both are asserted, PCSrcE wins.
- A memory access that completes in the same cycle it is requested (MemReqM && MemReadyM in RUN) produces no stall.
- Reset asserted mid-MEM_WAIT or in TRAP returns the FSM to RUN immediately.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - adds outputs StallCnt[CNT_W] and FlushCnt[CNT_W], both reset to 0.
  - StallCnt increments on every cycle with StallF=1.
  - FlushCnt increments on every cycle with FlushD||FlushE.
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent; the rest of the block's behaviour is identical.

Decomposition:
- hazard_pkg contains:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - hz_state_t enum: RUN, MEM_WAIT, TRAP;
  - localparam REG_ZERO=5'd0.
- One sub-module, fwd_sel: a combinational forwarding comparator, instantiated twice (operands A and B).

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for exactly one cycle. With RdE=0 -> no stall.
- Branch: PCSrcE=1 together with LoadE=1, RdE=3, Rs1D=3 -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all Stall* and FlushW high for 3 cycles, low in the ready cycle; FSM back in RUN.
- Timeout: MEM_TIMEOUT=4, MemReadyM held at 0 -> TRAP entered after 4 stalled cycles, MemErr=1 sticky. A later MemReadyM=1 leaves stalls asserted; reset_n pulse clears MemErr and all outputs.
- HAZARD_PERF_EN: one load-use stall plus one branch -> StallCnt=1, FlushCnt=2. Preloading StallCnt near all-ones (force) -> it saturates and does not wrap.
